// File: rtl/complex_mult_pipe_if.sv
// Operand/product handshake bundle for complex_mult_pipe.
interface complex_mult_pipe_if #(
    parameter int unsigned SAT_CNT_W = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          in_a;
    logic [31:0]          in_b;
    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          out_p;
    logic                 out_sat;
    logic [SAT_CNT_W-1:0] sat_count;
    logic                 sat_clr;

    modport master (
        output in_valid, in_a, in_b, out_ready, sat_clr,
        input  in_ready, out_valid, out_p, out_sat, sat_count
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready, sat_clr,
        output in_ready, out_valid, out_p, out_sat, sat_count
    );
endinterface

// File: rtl/complex_mult_pipe.sv
// Three-stage Q3.13 complex multiplier with round-half-up, saturation and a
// sticky saturation event counter; one global stall enable drives all stages.
module complex_mult_pipe #(
    parameter int unsigned SAT_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    complex_mult_pipe_if.slave    bus
);
    localparam int unsigned HALF_W = 16;
    localparam int unsigned PROD_W = 32;
    localparam int unsigned ACC_W  = 34;
    localparam int unsigned FRAC_W = 13;

    localparam logic signed [ACC_W-1:0] RND_C   = ACC_W'(1 << (FRAC_W - 1));
    localparam logic signed [ACC_W-1:0] POS_MAX = ACC_W'((2 ** (HALF_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] NEG_MIN = -ACC_W'(2 ** (HALF_W - 1));

    typedef struct packed {
        logic signed [HALF_W-1:0] re;
        logic signed [HALF_W-1:0] im;
    } complex_t;

    // Returns {saturated, clamped value} for a rounded, shifted accumulator.
    function automatic logic [HALF_W:0] sat_fn(input logic signed [ACC_W-1:0] v);
        if (v > POS_MAX) begin
            return {1'b1, HALF_W'(POS_MAX)};
        end else if (v < NEG_MIN) begin
            return {1'b1, HALF_W'(NEG_MIN)};
        end
        return {1'b0, v[HALF_W-1:0]};
    endfunction

    logic en;

    logic                     s1_valid_q, s1_valid_d;
    complex_t                 s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic                     s2_valid_q, s2_valid_d;
    logic signed [PROD_W-1:0] s2_rr_q, s2_rr_d, s2_ii_q, s2_ii_d;
    logic signed [PROD_W-1:0] s2_ri_q, s2_ri_d, s2_ir_q, s2_ir_d;
    logic                     out_valid_q, out_valid_d;
    complex_t                 out_p_q, out_p_d;
    logic                     out_sat_q, out_sat_d;
    logic [SAT_CNT_W-1:0]     sat_count_q, sat_count_d;

    logic signed [ACC_W-1:0]  re_full, im_full, re_sh, im_sh;
    logic [HALF_W:0]          re_res, im_res;

    // Sum of cross products, round half-up toward +inf, then clamp.
    always_comb begin
        re_full = ACC_W'(s2_rr_q) - ACC_W'(s2_ii_q);
        im_full = ACC_W'(s2_ri_q) + ACC_W'(s2_ir_q);
        re_sh   = (re_full + RND_C) >>> FRAC_W;
        im_sh   = (im_full + RND_C) >>> FRAC_W;
        re_res  = sat_fn(re_sh);
        im_res  = sat_fn(im_sh);
    end

    always_comb begin
        en          = !out_valid_q || bus.out_ready;
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s2_valid_d  = s2_valid_q;
        s2_rr_d     = s2_rr_q;
        s2_ii_d     = s2_ii_q;
        s2_ri_d     = s2_ri_q;
        s2_ir_d     = s2_ir_q;
        out_valid_d = out_valid_q;
        out_p_d     = out_p_q;
        out_sat_d   = out_sat_q;
        sat_count_d = sat_count_q;

        if (en) begin
            s1_valid_d  = bus.in_valid;
            s1_a_d      = bus.in_a;
            s1_b_d      = bus.in_b;
            s2_valid_d  = s1_valid_q;
            s2_rr_d     = PROD_W'(s1_a_q.re) * PROD_W'(s1_b_q.re);
            s2_ii_d     = PROD_W'(s1_a_q.im) * PROD_W'(s1_b_q.im);
            s2_ri_d     = PROD_W'(s1_a_q.re) * PROD_W'(s1_b_q.im);
            s2_ir_d     = PROD_W'(s1_a_q.im) * PROD_W'(s1_b_q.re);
            out_valid_d = s2_valid_q;
            out_p_d     = {re_res[HALF_W-1:0], im_res[HALF_W-1:0]};
            out_sat_d   = re_res[HALF_W] | im_res[HALF_W];
        end

        // Clear wins over a same-cycle saturated transfer; count sticks at max.
        if (bus.sat_clr) begin
            sat_count_d = '0;
        end else if (out_valid_q && bus.out_ready && out_sat_q && (sat_count_q != '1)) begin
            sat_count_d = sat_count_q + SAT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_p_q     <= '0;
            out_sat_q   <= 1'b0;
            sat_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            out_valid_q <= out_valid_d;
            out_p_q     <= out_p_d;
            out_sat_q   <= out_sat_d;
            sat_count_q <= sat_count_d;
        end
    end

    // Datapath registers carry no reset; their valids gate them.
    always_ff @(posedge clk) begin
        s1_a_q  <= s1_a_d;
        s1_b_q  <= s1_b_d;
        s2_rr_q <= s2_rr_d;
        s2_ii_q <= s2_ii_d;
        s2_ri_q <= s2_ri_d;
        s2_ir_q <= s2_ir_d;
    end

    assign bus.in_ready  = en;
    assign bus.out_valid = out_valid_q;
    assign bus.out_p     = out_p_q;
    assign bus.out_sat   = out_sat_q;
    assign bus.sat_count = sat_count_q;
endmodule

// File: tb/tb_complex_mult_pipe.sv
// Scoreboard bench for complex_mult_pipe: directed products, random backpressure,
// saturation counter (16- and 2-bit) and reset while items are in flight.
module tb_complex_mult_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    complex_mult_pipe_if #(.SAT_CNT_W(16)) bus0();
    complex_mult_pipe_if #(.SAT_CNT_W(2))  bus1();

    complex_mult_pipe #(.SAT_CNT_W(16)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    complex_mult_pipe #(.SAT_CNT_W(2))  dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int     vectors     = 0;
    int     miscompares = 0;
    longint cyc         = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] p;
        logic        sat;
        longint      t;
    } exp_t;
    exp_t sb[$];

    localparam logic [31:0] SAT_OP = 32'h8000_0000;

    function automatic logic [15:0] q16(input longint v, output logic s);
        real    r;
        longint q;
        r = $floor((real'(v) + 4096.0) / 8192.0);
        q = longint'(r);
        s = 1'b0;
        if (q > 32767) begin
            q = 32767;
            s = 1'b1;
        end else if (q < -32768) begin
            q = -32768;
            s = 1'b1;
        end
        return 16'(q);
    endfunction

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input longint t);
        exp_t        e;
        longint      ar, ai, br, bi, re, im;
        logic        sr, si;
        logic [15:0] pr, pi;
        ar = longint'($signed(a[31:16]));
        ai = longint'($signed(a[15:0]));
        br = longint'($signed(b[31:16]));
        bi = longint'($signed(b[15:0]));
        re = ar * br - ai * bi;
        im = ar * bi + ai * br;
        pr = q16(re, sr);
        pi = q16(im, si);
        e.p   = {pr, pi};
        e.sat = sr | si;
        e.t   = t;
        return e;
    endfunction

    task automatic idle_inputs();
        bus0.in_valid = 1'b0; bus0.in_a = '0; bus0.in_b = '0;
        bus0.out_ready = 1'b1; bus0.sat_clr = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0;
        bus1.out_ready = 1'b1; bus1.sat_clr = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if ({bus0.out_valid, bus0.out_sat, bus0.out_p} !== 34'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got valid=%b sat=%b p=%h, expected 0/0/00000000",
                     bus0.out_valid, bus0.out_sat, bus0.out_p);
        end
        vectors++;
        if (bus0.sat_count !== 16'h0 || bus1.sat_count !== 2'h0 || bus1.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_counts: got %h/%h valid1=%b, expected 0/0/0",
                     bus0.sat_count, bus1.sat_count, bus1.out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (bus0.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b, expected 1", bus0.in_ready);
        end
    endtask

    task automatic test_directed();
        localparam int N = 11;
        logic [31:0] va [N] = '{32'h2000_0000, 32'h0001_0000, 32'h0001_0000, 32'hFFFF_0000,
                                32'h4000_4000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                                32'h0000_2000, 32'hFFFF_0000, 32'h4000_4000};
        logic [31:0] vb [N] = '{32'h1000_1000, 32'h1000_0000, 32'h0FFF_0000, 32'h1000_0000,
                                32'h4000_C000, 32'h8000_0000, 32'h7FFF_0000, 32'h2000_0000,
                                32'h1000_1000, 32'h3000_0000, 32'h4000_4000};
        logic [31:0] vp [N] = '{32'h1000_1000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0000,
                                32'h7FFF_0000, 32'h7FFF_0000, 32'h8000_0000, 32'h8000_0000,
                                32'hF000_1000, 32'hFFFF_0000, 32'h0000_7FFF};
        logic        vs [N] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        int   idx = 0;
        int   got = 0;
        int   n   = 0;
        exp_t e;
        sb.delete();
        bus0.out_ready = 1'b1;
        while (got < N && n < 200) begin
            @(negedge clk);
            n++;
            bus0.in_valid = (idx < N);
            if (idx < N) begin
                bus0.in_a = va[idx];
                bus0.in_b = vb[idx];
            end
            #1;
            if (bus0.out_valid && bus0.out_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL directed_extra: got p=%h with nothing outstanding", bus0.out_p);
                end else begin
                    e = sb.pop_front();
                    if (bus0.out_p !== e.p || bus0.out_sat !== e.sat || (cyc - e.t) != 3) begin
                        miscompares++;
                        $display("FAIL directed_%0d: got p=%h sat=%b lat=%0d, expected p=%h sat=%b lat=3",
                                 got, bus0.out_p, bus0.out_sat, cyc - e.t, e.p, e.sat);
                    end
                end
                got++;
            end
            if (bus0.in_valid && bus0.in_ready) begin
                sb.push_back('{vp[idx], vs[idx], cyc});
                idx++;
            end
        end
        bus0.in_valid = 1'b0;
        if (got < N) begin
            vectors++;
            miscompares++;
            $display("FAIL directed_timeout: got %0d outputs, expected %0d", got, N);
        end
    endtask

    task automatic test_backpressure();
        localparam int N = 20;
        int          sent = 0;
        int          got  = 0;
        int          n    = 0;
        logic        held_v = 1'b0;
        logic        held_s = 1'b0;
        logic [31:0] held_p = '0;
        logic [31:0] a, b;
        exp_t        e;
        sb.delete();
        a = $urandom; b = $urandom;
        while ((got < N || sb.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
            bus0.out_ready = 1'($urandom_range(0, 1));
            bus0.in_valid  = (sent < N) && ($urandom_range(0, 3) != 0);
            bus0.in_a = a;
            bus0.in_b = b;
            #1;
            if (held_v) begin
                vectors++;
                if ({bus0.out_valid, bus0.out_sat, bus0.out_p} !== {1'b1, held_s, held_p}) begin
                    miscompares++;
                    $display("FAIL stall_hold: got valid=%b sat=%b p=%h, expected 1/%b/%h",
                             bus0.out_valid, bus0.out_sat, bus0.out_p, held_s, held_p);
                end
            end
            held_v = bus0.out_valid && !bus0.out_ready;
            held_p = bus0.out_p;
            held_s = bus0.out_sat;
            if (bus0.out_valid && bus0.out_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL bp_extra: got p=%h with nothing outstanding", bus0.out_p);
                end else begin
                    e = sb.pop_front();
                    if (bus0.out_p !== e.p || bus0.out_sat !== e.sat) begin
                        miscompares++;
                        $display("FAIL bp_item_%0d: got p=%h sat=%b, expected p=%h sat=%b",
                                 got, bus0.out_p, bus0.out_sat, e.p, e.sat);
                    end
                end
                got++;
            end
            if (bus0.in_valid && bus0.in_ready) begin
                sb.push_back(model(a, b, cyc));
                sent++;
                a = $urandom; b = $urandom;
                if ($urandom_range(0, 1) == 1) a = {{3{a[31]}}, a[31:19], {3{a[15]}}, a[15:3]};
            end
        end
        bus0.in_valid  = 1'b0;
        bus0.out_ready = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        vectors++;
        if (got != N || bus0.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_count: got %0d outputs valid=%b, expected %0d and idle", got, bus0.out_valid, N);
        end
    endtask

    task automatic test_counter();
        int acc  = 0;
        int outs = 0;
        int n    = 0;
        @(negedge clk);
        bus0.sat_clr = 1'b1;
        @(negedge clk);
        bus0.sat_clr = 1'b0;
        #1;
        vectors++;
        if (bus0.sat_count !== 16'd0) begin
            miscompares++;
            $display("FAIL cnt_clear: got %0d, expected 0", bus0.sat_count);
        end
        bus0.in_a = SAT_OP; bus0.in_b = SAT_OP; bus0.out_ready = 1'b1;
        while (outs < 3 && n < 50) begin
            @(negedge clk);
            n++;
            bus0.in_valid = (acc < 3);
            #1;
            if (bus0.out_valid) begin
                vectors++;
                if (bus0.out_p !== 32'h7FFF_0000 || bus0.out_sat !== 1'b1) begin
                    miscompares++;
                    $display("FAIL cnt_item: got p=%h sat=%b, expected 7fff0000/1", bus0.out_p, bus0.out_sat);
                end
                outs++;
            end
            if (bus0.in_valid && bus0.in_ready) acc++;
        end
        bus0.in_valid = 1'b0;
        @(negedge clk);
        #1;
        vectors++;
        if (bus0.sat_count !== 16'd3) begin
            miscompares++;
            $display("FAIL cnt_three: got %0d, expected 3", bus0.sat_count);
        end
        // Park a fourth saturated item at the output, then clear as it leaves.
        bus0.out_ready = 1'b0;
        bus0.in_valid  = 1'b1;
        @(negedge clk);
        bus0.in_valid = 1'b0;
        n = 0;
        #1;
        while (!bus0.out_valid && n < 10) begin
            @(negedge clk);
            n++;
            #1;
        end
        bus0.sat_clr   = 1'b1;
        bus0.out_ready = 1'b1;
        #1;
        vectors++;
        if (bus0.out_valid !== 1'b1 || bus0.out_sat !== 1'b1 || bus0.sat_count !== 16'd3) begin
            miscompares++;
            $display("FAIL cnt_fourth: got valid=%b sat=%b cnt=%0d, expected 1/1/3",
                     bus0.out_valid, bus0.out_sat, bus0.sat_count);
        end
        @(negedge clk);
        bus0.sat_clr = 1'b0;
        #1;
        vectors++;
        if (bus0.sat_count !== 16'd0 || bus0.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL cnt_clr_priority: got cnt=%0d valid=%b, expected 0/0", bus0.sat_count, bus0.out_valid);
        end
        bus0.in_valid = 1'b1;
        @(negedge clk);
        bus0.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        vectors++;
        if (bus0.sat_count !== 16'd1) begin
            miscompares++;
            $display("FAIL cnt_after_clr: got %0d, expected 1", bus0.sat_count);
        end
    endtask

    task automatic test_counter_narrow();
        int acc  = 0;
        int outs = 0;
        int n    = 0;
        bus1.in_a = SAT_OP; bus1.in_b = SAT_OP; bus1.out_ready = 1'b1;
        while (outs < 5 && n < 60) begin
            @(negedge clk);
            n++;
            bus1.in_valid = (acc < 5);
            #1;
            if (bus1.out_valid) outs++;
            if (bus1.in_valid && bus1.in_ready) acc++;
        end
        bus1.in_valid = 1'b0;
        @(negedge clk);
        #1;
        vectors++;
        if (outs != 5 || bus1.sat_count !== 2'd3) begin
            miscompares++;
            $display("FAIL cnt_narrow_sticky: got cnt=%0d after %0d outputs, expected 3 after 5",
                     bus1.sat_count, outs);
        end
    endtask

    task automatic test_reset_midstream();
        logic   seen = 1'b0;
        int     n    = 0;
        longint t;
        bus0.out_ready = 1'b1;
        bus0.in_a = SAT_OP; bus0.in_b = SAT_OP;
        repeat (3) begin
            @(negedge clk);
            bus0.in_valid = 1'b1;
        end
        @(negedge clk);
        bus0.in_valid  = 1'b0;
        bus0.out_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        vectors++;
        if (bus0.out_valid !== 1'b0 || bus0.sat_count !== 16'd0 || bus0.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_state: got valid=%b cnt=%0d rdy=%b, expected 0/0/1",
                     bus0.out_valid, bus0.sat_count, bus0.in_ready);
        end
        rst = 1'b0;
        bus0.out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            #1;
            if (bus0.out_valid) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_dropped: got a stale output, expected none");
        end
        @(negedge clk);
        bus0.in_a = 32'h0000_2000; bus0.in_b = 32'h1000_1000; bus0.in_valid = 1'b1;
        #1;
        t = cyc;
        @(negedge clk);
        bus0.in_valid = 1'b0;
        #1;
        while (!bus0.out_valid && n < 10) begin
            @(negedge clk);
            n++;
            #1;
        end
        vectors++;
        if (bus0.out_valid !== 1'b1 || bus0.out_p !== 32'hF000_1000 || bus0.out_sat !== 1'b0 || (cyc - t) != 3) begin
            miscompares++;
            $display("FAIL midrst_first: got valid=%b p=%h sat=%b lat=%0d, expected 1/f0001000/0/3",
                     bus0.out_valid, bus0.out_p, bus0.out_sat, cyc - t);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_counter();
        test_counter_narrow();
        test_reset_midstream();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
